// File: rtl/legv8_datapath_ts.sv
// Single-cycle LEGv8 datapath: 32x64 register file, 64-bit ALU with flags and a
// 64-bit data RAM, all exchanging values over one shared tri-state bus.
module legv8_datapath_ts #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ControlWord,
    inout  wire  [63:0] data,
    output logic [31:0] address,
    input  logic [63:0] constant,
    output logic [3:0]  status,
    input  logic [31:0] IR_out,
    input  logic [3:0]  SR_out,
    output logic [15:0] r0,
    output logic [15:0] r1,
    output logic [15:0] r2,
    output logic [15:0] r3,
    output logic [15:0] r4,
    output logic [15:0] r5,
    output logic [15:0] r6,
    output logic [15:0] r7
);
    localparam int IW = $clog2(MEM_WORDS);

    logic [4:0]    da, sa, sb, fs;
    logic          bsel, reg_write, c0, addr_en, alu_bus, mem_write, mem_en, b_bus, mem_read;
    logic [63:0]   regs [32];
    logic [63:0]   mem [MEM_WORDS];
    logic [63:0]   a_val, b_val, b_mux, a_op, b_op, alu_result, mem_q;
    logic [64:0]   sum;
    logic          carry, overflow, mem_drive;
    logic [IW-1:0] idx;

    assign da        = ControlWord[4:0];
    assign sa        = ControlWord[9:5];
    assign sb        = ControlWord[14:10];
    assign bsel      = ControlWord[15];
    assign reg_write = ControlWord[16];
    assign fs        = ControlWord[21:17];
    assign c0        = ControlWord[22];
    assign addr_en   = ControlWord[23];
    assign alu_bus   = ControlWord[24];
    assign mem_write = ControlWord[25];
    assign mem_en    = ControlWord[26];
    assign b_bus     = ControlWord[29];
    assign mem_read  = ControlWord[30];

    // Reserved inputs and the fixed doubleword size field do not steer anything.
    logic unused;
    assign unused = ^{IR_out, SR_out, ControlWord[31], ControlWord[28:27]};

    // NOTE: the register file is reset entry by entry; the RAM below is a true
    // memory and deliberately has no reset so it can map onto a RAM macro.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_write && da != 5'd31) begin
            regs[da] <= data;
        end
    end

    assign a_val = (sa == 5'd31) ? '0 : regs[sa];
    assign b_val = (sb == 5'd31) ? '0 : regs[sb];

    // NOTE: every always_comb output gets a default before the case so no
    // path through the block can leave a value held (which would infer a latch).
    always_comb begin
        b_mux      = bsel ? constant : b_val;
        a_op       = fs[1] ? ~a_val : a_val;
        b_op       = fs[0] ? ~b_mux : b_mux;
        sum        = {1'b0, a_op} + {1'b0, b_op} + {64'd0, c0};
        alu_result = '0;
        carry      = 1'b0;
        overflow   = 1'b0;
        case (fs[4:2])
            3'b000: alu_result = a_op & b_op;
            3'b001: alu_result = a_op | b_op;
            3'b010: begin
                alu_result = sum[63:0];
                carry      = sum[64];
                overflow   = (a_op[63] == b_op[63]) && (sum[63] != a_op[63]);
            end
            3'b011: alu_result = a_op ^ b_op;
            3'b100: alu_result = a_val << b_mux[5:0];
            3'b101: alu_result = a_val >> b_mux[5:0];
            3'b110: alu_result = a_op;
            default: alu_result = b_op;
        endcase
    end

    assign status  = {overflow, carry, alu_result[63], alu_result == 64'd0};
    assign address = addr_en ? alu_result[31:0] : 32'd0;
    assign idx     = address[IW+2:3];

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!reset && mem_en && mem_write) mem[idx] <= data;
    end

    assign mem_q     = mem[idx];
    assign mem_drive = mem_en & mem_read & ~mem_write;

    // The control unit enables at most one source; the priority only fixes a single driver.
    assign data = alu_bus   ? alu_result :
                  b_bus     ? b_val      :
                  mem_drive ? mem_q      : 64'bz;

    assign r0 = regs[0][15:0];
    assign r1 = regs[1][15:0];
    assign r2 = regs[2][15:0];
    assign r3 = regs[3][15:0];
    assign r4 = regs[4][15:0];
    assign r5 = regs[5][15:0];
    assign r6 = regs[6][15:0];
    assign r7 = regs[7][15:0];
endmodule

// File: tb/tb_legv8_datapath_ts.sv
// Bench for legv8_datapath_ts: directed program from the datapath's worked example
// plus randomized instructions checked against an arithmetic reference model.
module tb_legv8_datapath_ts;
    localparam int MEM_WORDS = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ControlWord;
    wire  [63:0] data;
    logic [31:0] address;
    logic [63:0] constant;
    logic [3:0]  status;
    logic [31:0] IR_out;
    logic [3:0]  SR_out;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [15:0] r_dut [8];

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [63:0] rf_m  [32];
    logic [63:0] mem_m [MEM_WORDS];
    int          written_q[$];

    logic [3:0]  exp_status, obs_status;
    logic [31:0] exp_addr, obs_addr;
    logic [63:0] exp_bus, obs_bus;
    logic        exp_bus_en;

    legv8_datapath_ts #(.MEM_WORDS(MEM_WORDS)) dut (
        .clock(clock), .reset(reset), .ControlWord(ControlWord), .data(data),
        .address(address), .constant(constant), .status(status),
        .IR_out(IR_out), .SR_out(SR_out),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7)
    );

    assign r_dut[0] = r0;
    assign r_dut[1] = r1;
    assign r_dut[2] = r2;
    assign r_dut[3] = r3;
    assign r_dut[4] = r4;
    assign r_dut[5] = r5;
    assign r_dut[6] = r6;
    assign r_dut[7] = r7;

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_cw(input logic [4:0] da, sa, sb, fs,
                                          input logic bsel, regw, c0, addr_en, alu_bus,
                                          input logic mem_w, mem_en, b_bus, mem_rd);
        return {1'b0, mem_rd, b_bus, 2'b11, mem_en, mem_w, alu_bus, addr_en, c0,
                fs, regw, bsel, sb, sa, da};
    endfunction

    // Reference datapath: evaluates one control word from the model state.
    function automatic void model_eval(input logic [31:0] cw, input logic [63:0] k);
        logic [63:0] a, b, ap, bp, res;
        logic [127:0] u;
        logic signed [127:0] s, smax, smin;
        logic c, v;
        int idx;
        a  = (cw[9:5] == 5'd31) ? 64'd0 : rf_m[cw[9:5]];
        b  = cw[15] ? k : ((cw[14:10] == 5'd31) ? 64'd0 : rf_m[cw[14:10]]);
        ap = cw[18] ? ~a : a;
        bp = cw[17] ? ~b : b;
        u  = 128'(ap) + 128'(bp) + 128'(cw[22]);
        s  = $signed({64'd0, ap}) - (ap[63] ? (128'sd1 <<< 64) : 128'sd0)
           + $signed({64'd0, bp}) - (bp[63] ? (128'sd1 <<< 64) : 128'sd0)
           + (cw[22] ? 128'sd1 : 128'sd0);
        smax = (128'sd1 <<< 63) - 128'sd1;
        smin = -(128'sd1 <<< 63);
        c = 1'b0;
        v = 1'b0;
        case (cw[21:19])
            3'd0: res = ap & bp;
            3'd1: res = ap | bp;
            3'd2: begin
                res = u[63:0];
                c   = (u >> 64) != 0;
                v   = (s > smax) || (s < smin);
            end
            3'd3: res = ap ^ bp;
            3'd4: res = a << b[5:0];
            3'd5: res = a >> b[5:0];
            3'd6: res = ap;
            default: res = bp;
        endcase
        exp_status = {v, c, res[63], res == 64'd0};
        exp_addr   = cw[23] ? res[31:0] : 32'd0;
        idx        = int'(exp_addr[10:3]);
        exp_bus_en = 1'b1;
        if (cw[24])                          exp_bus = res;
        else if (cw[29])                     exp_bus = (cw[14:10] == 5'd31) ? 64'd0 : rf_m[cw[14:10]];
        else if (cw[26] && cw[30] && !cw[25]) exp_bus = mem_m[idx];
        else begin
            exp_bus    = 64'd0;
            exp_bus_en = 1'b0;
        end
    endfunction

    function automatic void model_commit(input logic [31:0] cw, input logic rst);
        int idx;
        idx = int'(exp_addr[10:3]);
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_m[i] = 64'd0;
        end else begin
            if (cw[16] && cw[4:0] != 5'd31) rf_m[cw[4:0]] = exp_bus;
            if (cw[26] && cw[25]) begin
                mem_m[idx] = exp_bus;
                written_q.push_back(idx);
            end
        end
    endfunction

    // One instruction: drive, sample combinational outputs at negedge, clock it.
    task automatic cycle(input logic [31:0] cw, input logic [63:0] k);
        ControlWord = cw;
        constant    = k;
        model_eval(cw, k);
        @(negedge clock);
        obs_status = status;
        obs_addr   = address;
        obs_bus    = data;
        @(posedge clock);
        #1;
        model_commit(cw, reset);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        ControlWord = 32'd0;
        constant    = 64'd0;
        for (int i = 0; i < 32; i++) rf_m[i] = 64'd0;
        for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = 64'd0;
        @(posedge clock);
        #1;
        checks++;
        if (status !== 4'b0001) begin
            failures++;
            $display("FAIL reset_status got=%b want=0001", status);
        end
        checks++;
        if (address !== 32'd0) begin
            failures++;
            $display("FAIL reset_address got=%h want=0", address);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (r_dut[i] !== 16'd0) begin
                failures++;
                $display("FAIL reset_r%0d got=%h want=0000", i, r_dut[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_program();
        // X0 <- X31 | 24
        cycle(mk_cw(5'd0, 5'd31, 5'd1, 5'b00100, 1, 1, 0, 0, 1, 0, 0, 0, 0), 64'd24);
        checks++;
        if (obs_status !== 4'b0000) begin failures++; $display("FAIL orr_status got=%b want=0000", obs_status); end
        checks++;
        if (r0 !== 16'h0018) begin failures++; $display("FAIL orr_r0 got=%h want=0018", r0); end
        // X1 <- X31 - X0
        cycle(mk_cw(5'd1, 5'd31, 5'd0, 5'b01001, 0, 1, 1, 0, 1, 0, 0, 0, 0), 64'd0);
        checks++;
        if (obs_status !== 4'b0010) begin failures++; $display("FAIL sub_status got=%b want=0010", obs_status); end
        checks++;
        if (r1 !== 16'hFFE8) begin failures++; $display("FAIL sub_r1 got=%h want=ffe8", r1); end
        // M[X31+24] <- X1
        cycle(mk_cw(5'd0, 5'd31, 5'd1, 5'b01000, 1, 0, 0, 1, 0, 1, 1, 1, 0), 64'd24);
        checks++;
        if (obs_addr !== 32'd24) begin failures++; $display("FAIL stur_addr got=%h want=18", obs_addr); end
        checks++;
        if (obs_bus !== 64'hFFFF_FFFF_FFFF_FFE8) begin failures++; $display("FAIL stur_bus got=%h want=ffffffffffffffe8", obs_bus); end
        checks++;
        if (r0 !== 16'h0018 || r1 !== 16'hFFE8) begin failures++; $display("FAIL stur_regs got=%h/%h want=0018/ffe8", r0, r1); end
        // X1 <- X0 & X1
        cycle(mk_cw(5'd1, 5'd0, 5'd1, 5'b00000, 0, 1, 0, 0, 1, 0, 0, 0, 0), 64'd0);
        checks++;
        if (r1 !== 16'h0008) begin failures++; $display("FAIL and_r1 got=%h want=0008", r1); end
        // X2 <- M[X31+24]
        cycle(mk_cw(5'd2, 5'd31, 5'd1, 5'b01000, 1, 1, 0, 1, 0, 0, 1, 0, 1), 64'd24);
        checks++;
        if (obs_addr !== 32'd24) begin failures++; $display("FAIL ldur_addr got=%h want=18", obs_addr); end
        checks++;
        if (obs_bus !== 64'hFFFF_FFFF_FFFF_FFE8) begin failures++; $display("FAIL ldur_bus got=%h want=ffffffffffffffe8", obs_bus); end
        checks++;
        if (r2 !== 16'hFFE8) begin failures++; $display("FAIL ldur_r2 got=%h want=ffe8", r2); end
        // Write X31, then read it back through pass-A onto the address
        cycle(mk_cw(5'd31, 5'd31, 5'd31, 5'b11100, 1, 1, 0, 0, 1, 0, 0, 0, 0), 64'h1234);
        cycle(mk_cw(5'd0, 5'd31, 5'd31, 5'b11000, 0, 0, 0, 1, 1, 0, 0, 0, 0), 64'h1234);
        checks++;
        if (obs_status !== 4'b0001 || obs_addr !== 32'd0 || obs_bus !== 64'd0) begin
            failures++;
            $display("FAIL x31_zero got=%b/%h/%h want=0001/0/0", obs_status, obs_addr, obs_bus);
        end
    endtask

    task automatic test_random();
        logic [31:0] cw;
        logic [63:0] k;
        int kind, idx;
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 3);
            if (kind == 3 && written_q.size() == 0) kind = 0;
            case (kind)
                0, 1: begin
                    k = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
                    cw = mk_cw(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                               1'($urandom), 1, 1'($urandom), 1'($urandom),
                               kind == 0, 0, 0, kind == 1, 0);
                end
                2: begin
                    idx = $urandom_range(0, MEM_WORDS - 1);
                    k   = 64'((idx << 3) | $urandom_range(0, 7));
                    cw  = mk_cw(5'd0, 5'd31, 5'($urandom), 5'b01000, 1, 0, 0, 1, 0, 1, 1, 1, 0);
                end
                default: begin
                    idx = written_q[$urandom_range(0, written_q.size() - 1)];
                    k   = 64'((idx << 3) | $urandom_range(0, 7));
                    cw  = mk_cw(5'($urandom), 5'd31, 5'($urandom), 5'b01000, 1, 1, 0, 1, 0, 0, 1, 0, 1);
                end
            endcase
            cycle(cw, k);
            checks++;
            if (obs_status !== exp_status) begin
                failures++;
                $display("FAIL rand_status n=%0d cw=%h got=%b want=%b", n, cw, obs_status, exp_status);
            end
            checks++;
            if (obs_addr !== exp_addr) begin
                failures++;
                $display("FAIL rand_addr n=%0d cw=%h got=%h want=%h", n, cw, obs_addr, exp_addr);
            end
            if (exp_bus_en) begin
                checks++;
                if (obs_bus !== exp_bus) begin
                    failures++;
                    $display("FAIL rand_bus n=%0d cw=%h got=%h want=%h", n, cw, obs_bus, exp_bus);
                end
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (r_dut[i] !== rf_m[i][15:0]) begin
                    failures++;
                    $display("FAIL rand_r%0d n=%0d got=%h want=%h", i, n, r_dut[i], rf_m[i][15:0]);
                end
            end
        end
    endtask

    task automatic test_reset_priority();
        // M[200] <- 0xA5A5 via X3, then stage 0x5A5A in X4
        cycle(mk_cw(5'd3, 5'd31, 5'd31, 5'b11100, 1, 1, 0, 0, 1, 0, 0, 0, 0), 64'hA5A5);
        cycle(mk_cw(5'd0, 5'd31, 5'd3, 5'b01000, 1, 0, 0, 1, 0, 1, 1, 1, 0), 64'd1600);
        cycle(mk_cw(5'd4, 5'd31, 5'd31, 5'b11100, 1, 1, 0, 0, 1, 0, 0, 0, 0), 64'h5A5A);
        // Under reset: store X4 to M[200] and copy X4 into X5 -- both must be blocked
        reset = 1'b1;
        cycle(mk_cw(5'd5, 5'd31, 5'd4, 5'b01000, 1, 1, 0, 1, 0, 1, 1, 1, 0), 64'd1600);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (r_dut[i] !== 16'd0) begin
                failures++;
                $display("FAIL rstprio_r%0d got=%h want=0000", i, r_dut[i]);
            end
        end
        cycle(mk_cw(5'd6, 5'd31, 5'd31, 5'b01000, 1, 1, 0, 1, 0, 0, 1, 0, 1), 64'd1600);
        checks++;
        if (obs_bus !== 64'hA5A5) begin
            failures++;
            $display("FAIL rstprio_mem got=%h want=a5a5", obs_bus);
        end
        checks++;
        if (r6 !== 16'hA5A5) begin
            failures++;
            $display("FAIL rstprio_r6 got=%h want=a5a5", r6);
        end
    endtask

    initial begin
        reset       = 1'b1;
        ControlWord = 32'd0;
        constant    = 64'd0;
        IR_out      = 32'hDEAD_BEEF;
        SR_out      = 4'hF;
        test_reset();
        test_program();
        test_random();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
